// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_controller
// Description : Control FSM for a 3-stage pipeline (PC -> R1 -> R2 -> R3).
//               Sequences stalls on data-memory wait, flushes after taken
//               jumps, load-use freezes and HALT, and keeps saturating
//               counters of stall cycles and accepted jumps.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_controller #(
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             update_pc,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             ir_en,
    output logic             r2_en,
    output logic             r3_en,
    output logic             bubble_r2,
    output logic             flush_r1,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Number of FLUSH cycles that follow the jump cycle itself.
    localparam logic [1:0] c_flush_init = 2'(FLUSH_LEN);

    state_t           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_pc_en, w_ir_en, w_r2_en, w_r3_en;
    logic w_bubble, w_flush, w_halted;
    logic w_jump_accepted;

    // State, flush-length counter and event counters; reset abandons any sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and pipeline enables; event priority mem_busy > update_pc > freeze > halt_req.
    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        w_pc_en         = 1'b1;
        w_ir_en         = 1'b1;
        w_r2_en         = 1'b1;
        w_r3_en         = 1'b1;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        w_halted        = 1'b0;
        w_jump_accepted = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    {w_pc_en, w_ir_en, w_r2_en, w_r3_en} = 4'b0000;
                    state_d = ST_STALL;
                end else if (update_pc) begin
                    // Jump cycle: squash the wrong-path fetch and the instruction in R1.
                    w_flush         = 1'b1;
                    w_bubble        = 1'b1;
                    w_jump_accepted = 1'b1;
                    fcnt_d          = c_flush_init;
                    state_d         = ST_FLUSH;
                end else if (freeze || halt_req) begin
                    // Hold PC and R1, let the older instructions drain past a bubble.
                    w_pc_en  = 1'b0;
                    w_ir_en  = 1'b0;
                    w_bubble = 1'b1;
                    if (!freeze) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_STALL: begin
                if (mem_busy) begin
                    {w_pc_en, w_ir_en, w_r2_en, w_r3_en} = 4'b0000;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_bubble = 1'b1;
                if (mem_busy) begin
                    {w_pc_en, w_ir_en, w_r2_en, w_r3_en} = 4'b0000;
                end else begin
                    fcnt_d = (fcnt_q == 2'd0) ? 2'd0 : fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                w_pc_en  = 1'b0;
                w_ir_en  = 1'b0;
                w_bubble = 1'b1;
                w_halted = 1'b1;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating counters: stalled cycles outside HALT, and accepted jumps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!w_pc_en && (state_q != ST_HALT) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_jump_accepted && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // While reset is asserted the pipeline is frozen and NOPs are forced in.
    assign pc_en     = rst_n & w_pc_en;
    assign ir_en     = rst_n & w_ir_en;
    assign r2_en     = rst_n & w_r2_en;
    assign r3_en     = rst_n & w_r3_en;
    assign bubble_r2 = ~rst_n | w_bubble;
    assign flush_r1  = ~rst_n | w_flush;
    assign halted    = rst_n & w_halted;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_controller
// Description : Self-checking bench for pipeline_controller: directed
//               scenarios plus randomized traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    localparam int FLUSH_LEN = 2;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n, freeze, update_pc, mem_busy, halt_req, resume;
    logic pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, halted;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_controller #(.FLUSH_LEN(FLUSH_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .update_pc(update_pc),
        .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .ir_en(ir_en), .r2_en(r2_en), .r3_en(r3_en),
        .bubble_r2(bubble_r2), .flush_r1(flush_r1), .halted(halted),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        freeze = 0; update_pc = 0; mem_busy = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        #3;
        @(negedge clk);
        n_cmp++;
        if ({pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, halted, state} !== 9'b0000_110_00) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b%b%b%b bub=%b fl=%b halt=%b st=%b, want en=0000 bub=1 fl=1 halt=0 st=00",
                     pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, halted, state);
        end
        n_cmp++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        rst_n = 1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if ({state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1} !== 8'b00_1111_00 ||
            stall_cnt !== 0 || flush_cnt !== 0) begin
            n_err++;
            $display("FAIL idle_run: got st=%b en=%b%b%b%b bub=%b fl=%b cnt=%0d/%0d, want st=00 en=1111 bub=0 fl=0 cnt=0/0",
                     state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_flush;
        do_reset();
        update_pc = 1;
        @(negedge clk);
        n_cmp++;
        if ({state, pc_en, ir_en, flush_r1, bubble_r2} !== 6'b00_1111) begin
            n_err++;
            $display("FAIL flush_cycle0: got st=%b pc=%b ir=%b fl=%b bub=%b, want 00 1 1 1 1",
                     state, pc_en, ir_en, flush_r1, bubble_r2);
        end
        tick();
        update_pc = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({state, bubble_r2, flush_r1, pc_en} !== 5'b10_101) begin
                n_err++;
                $display("FAIL flush_cycle%0d: got st=%b bub=%b fl=%b pc=%b, want 10 1 0 1",
                         i, state, bubble_r2, flush_r1, pc_en);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || bubble_r2 !== 1'b0 || flush_cnt !== 1) begin
            n_err++;
            $display("FAIL flush_done: got st=%b bub=%b flush_cnt=%0d, want 00 0 1", state, bubble_r2, flush_cnt);
        end
    endtask

    task automatic test_stall;
        do_reset();
        freeze = 1;
        @(negedge clk);
        n_cmp++;
        if ({state, pc_en, ir_en, r2_en, r3_en, bubble_r2} !== 7'b00_00111) begin
            n_err++;
            $display("FAIL freeze_outputs: got st=%b en=%b%b%b%b bub=%b, want 00 0011 1",
                     state, pc_en, ir_en, r2_en, r3_en, bubble_r2);
        end
        tick();
        freeze = 0;
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({pc_en, ir_en, r2_en, r3_en} !== 4'b0000 || state !== ((i == 0) ? 2'b00 : 2'b01)) begin
                n_err++;
                $display("FAIL busy_cycle%0d: got st=%b en=%b%b%b%b, want st=%b en=0000",
                         i, state, pc_en, ir_en, r2_en, r3_en, (i == 0) ? 2'b00 : 2'b01);
            end
            tick();
        end
        mem_busy = 0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b01 || {pc_en, ir_en, r2_en, r3_en} !== 4'b1111) begin
            n_err++;
            $display("FAIL stall_release: got st=%b en=%b%b%b%b, want 01 1111", state, pc_en, ir_en, r2_en, r3_en);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || stall_cnt !== 5) begin
            n_err++;
            $display("FAIL stall_count: got st=%b stall_cnt=%0d, want 00 5", state, stall_cnt);
        end
    endtask

    task automatic test_priority;
        do_reset();
        update_pc = 1;
        mem_busy  = 1;
        @(negedge clk);
        n_cmp++;
        if (pc_en !== 1'b0 || flush_r1 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_over_jump: got pc=%b fl=%b, want 0 0", pc_en, flush_r1);
        end
        tick();
        mem_busy = 0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b01 || flush_cnt !== 0 || flush_r1 !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ignores_jump: got st=%b flush_cnt=%0d fl=%b, want 01 0 0", state, flush_cnt, flush_r1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || flush_r1 !== 1'b1) begin
            n_err++;
            $display("FAIL jump_after_stall: got st=%b fl=%b, want 00 1", state, flush_r1);
        end
        tick();
        update_pc = 0;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b10 || flush_cnt !== 1) begin
            n_err++;
            $display("FAIL flush_entered: got st=%b flush_cnt=%0d, want 10 1", state, flush_cnt);
        end
    endtask

    task automatic test_halt;
        do_reset();
        halt_req = 1;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || pc_en !== 1'b0 || halted !== 1'b0 || bubble_r2 !== 1'b1) begin
            n_err++;
            $display("FAIL halt_entry: got st=%b pc=%b halted=%b bub=%b, want 00 0 0 1", state, pc_en, halted, bubble_r2);
        end
        tick();
        halt_req = 0;
        for (int i = 0; i < 6; i++) begin
            update_pc = (i == 2);
            freeze    = (i == 3);
            mem_busy  = (i == 4);
            resume    = (i == 5);
            @(negedge clk);
            n_cmp++;
            if ({state, halted, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1} !== 9'b11_1_0011_10) begin
                n_err++;
                $display("FAIL halt_cycle%0d: got st=%b halted=%b en=%b%b%b%b bub=%b fl=%b, want 11 1 0011 1 0",
                         i, state, halted, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || halted !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 1 || flush_cnt !== 0) begin
            n_err++;
            $display("FAIL halt_exit: got st=%b halted=%b pc=%b stall_cnt=%0d flush_cnt=%0d, want 00 0 1 1 0",
                     state, halted, pc_en, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturate_and_reset;
        do_reset();
        freeze = 1;
        repeat (300) tick();
        freeze = 0;
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== CNT_W'(CNT_MAX)) begin
            n_err++;
            $display("FAIL stall_saturate: got %0d, want %0d", stall_cnt, CNT_MAX);
        end
        // Reset in the middle of a FLUSH sequence.
        tick();
        update_pc = 1;
        tick();
        update_pc = 0;
        #1;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, halted} !== 9'b00_0000_110 ||
            stall_cnt !== 0 || flush_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_mid_flush: got st=%b en=%b%b%b%b bub=%b fl=%b halt=%b cnt=%0d/%0d, want 00 0000 1 1 0 0/0",
                     state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1, halted, stall_cnt, flush_cnt);
        end
        tick();
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1} !== 8'b00_1111_00) begin
            n_err++;
            $display("FAIL run_after_reset: got st=%b en=%b%b%b%b bub=%b fl=%b, want 00 1111 0 0",
                     state, pc_en, ir_en, r2_en, r3_en, bubble_r2, flush_r1);
        end
        // Reset in the middle of a STALL.
        tick();
        mem_busy = 1;
        repeat (2) tick();
        rst_n = 0;
        tick();
        mem_busy = 0;
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (state !== 2'b00 || pc_en !== 1'b1 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_mid_stall: got st=%b pc=%b stall_cnt=%0d, want 00 1 0", state, pc_en, stall_cnt);
        end
    endtask

    // Random traffic against a phase model: the controller is in normal flow,
    // waiting on memory, draining a jump (with a count of bubble cycles left),
    // or halted. Counters are tracked as plain integers.
    task automatic test_random;
        int  phase;      // 0 flow, 1 memory wait, 2 draining jump, 3 halted
        int  left;       // drain cycles still owed after the jump
        int  m_stall, m_jumps;
        int  nphase;
        bit  b, u, f, h, r;
        bit  e_pc, e_ir, e_r2, e_r3, e_bub, e_fl, e_halt;
        do_reset();
        phase = 0; left = 0; m_stall = 0; m_jumps = 0;
        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 99) < 20);
            u = ($urandom_range(0, 99) < 12);
            f = ($urandom_range(0, 99) < 15);
            h = ($urandom_range(0, 99) < 6);
            r = ($urandom_range(0, 99) < 30);
            mem_busy = b; update_pc = u; freeze = f; halt_req = h; resume = r;
            @(negedge clk);
            n_cmp++;
            if (state !== 2'(phase) || stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_jumps)) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got st=%b cnt=%0d/%0d, want st=%0d cnt=%0d/%0d",
                         i, state, stall_cnt, flush_cnt, phase, m_stall, m_jumps);
            end
            nphase = phase;
            {e_pc, e_ir, e_r2, e_r3} = 4'b1111;
            e_bub = 0; e_fl = 0; e_halt = 0;
            if (phase == 3) begin
                {e_pc, e_ir, e_bub, e_halt} = 4'b0011;
                if (r) nphase = 0;
            end else if (b) begin
                {e_pc, e_ir, e_r2, e_r3} = 4'b0000;
                if (phase == 0) nphase = 1;
            end else if (phase == 1) begin
                nphase = 0;
            end else if (phase == 2) begin
                e_bub = 1;
                left--;
                if (left == 0) nphase = 0;
            end else if (u) begin
                e_fl = 1; e_bub = 1;
                left = FLUSH_LEN;
                nphase = 2;
                if (m_jumps < CNT_MAX) m_jumps++;
            end else if (f || h) begin
                {e_pc, e_ir, e_bub} = 3'b001;
                if (!f) nphase = 3;
            end
            n_cmp++;
            if ({pc_en, ir_en, r2_en, r3_en, halted} !== {e_pc, e_ir, e_r2, e_r3, e_halt} ||
                (r2_en && bubble_r2 !== e_bub) || (ir_en && flush_r1 !== e_fl)) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got en=%b%b%b%b halt=%b bub=%b fl=%b, want en=%b%b%b%b halt=%b bub=%b fl=%b (in=b%0b u%0b f%0b h%0b r%0b)",
                         i, pc_en, ir_en, r2_en, r3_en, halted, bubble_r2, flush_r1,
                         e_pc, e_ir, e_r2, e_r3, e_halt, e_bub, e_fl, b, u, f, h, r);
            end
            if (!e_pc && phase != 3 && m_stall < CNT_MAX) m_stall++;
            phase = nphase;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_flush();
        test_stall();
        test_priority();
        test_halt();
        test_saturate_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 1: bubble cycles inserted into R2 after a taken jump (range 1..3).
REQ-002 SHALL have parameter CNT_W, default 8: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port freeze, input, 1: load-use hazard flag from the dependency detector.
REQ-006 SHALL have port update_pc, input, 1: taken jump resolved this cycle.
REQ-007 SHALL have port mem_busy, input, 1: data memory not ready (level).
REQ-008 SHALL have port halt_req, input, 1: HALT decoded in R1.
REQ-009 SHALL have port resume, input, 1: leave HALT.
REQ-010 SHALL have ports pc_en, ir_en, r2_en, r3_en, output, 1 each: load enables for PC, R1, R2 and R3.
REQ-011 SHALL have port bubble_r2, output, 1: load NOP into R2 instead of R1 contents.
REQ-012 SHALL have port flush_r1, output, 1: load NOP into R1.
REQ-013 SHALL have port halted, output, 1: high while in HALT.
REQ-014 SHALL have port state, output, 2: RUN=00, STALL=01, FLUSH=10, HALT=11.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: saturating event counters.

Function
REQ-016 SHALL be a Moore/Mealy FSM (RUN, STALL, FLUSH, HALT); outputs combinational from state and inputs.
REQ-017 SHALL apply event priority mem_busy > update_pc > freeze > halt_req in every state that samples them.
REQ-018 RUN, no event: SHALL drive all four enables 1, bubble_r2=0, flush_r1=0.
REQ-019 RUN + mem_busy: SHALL drive all enables 0 and go to STALL.
REQ-020 STALL: SHALL hold all enables 0 while mem_busy=1; on mem_busy=0, SHALL apply RUN outputs that cycle and return to RUN.
REQ-021 RUN + update_pc: SHALL drive pc_en=1, ir_en=1, r2_en=1, r3_en=1, flush_r1=1, bubble_r2=1, load a flush counter with FLUSH_LEN and go to FLUSH.
REQ-022 FLUSH: SHALL drive all enables 1, bubble_r2=1, flush_r1=0; SHALL decrement its counter each cycle and return to RUN when the counter reaches 0.
REQ-023 FLUSH + mem_busy: SHALL drive all enables 0 and hold the flush counter unchanged.
REQ-024 FLUSH SHALL ignore update_pc, freeze and halt_req; the flushed path cannot raise them.
REQ-025 RUN + freeze: SHALL drive pc_en=0, ir_en=0, r2_en=1, r3_en=1, bubble_r2=1 for that cycle, with no state change.
REQ-026 RUN + halt_req: SHALL apply freeze outputs this cycle and go to HALT.
REQ-027 HALT: SHALL drive pc_en=0, ir_en=0, r2_en=1, r3_en=1, bubble_r2=1, halted=1; on resume=1 SHALL return to RUN next cycle. update_pc and freeze SHALL be ignored in HALT.
REQ-028 stall_cnt SHALL increment by 1 in each cycle with pc_en=0 outside HALT, saturating at all-ones.
REQ-029 flush_cnt SHALL increment by 1 per accepted update_pc (REQ-021), saturating at all-ones.
REQ-030 resume SHALL be ignored outside HALT; halted SHALL be 0 outside HALT.

Reset
REQ-031 rst_n=0 SHALL immediately force state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0, halted=0.
REQ-032 While rst_n=0: SHALL force pc_en=ir_en=r2_en=r3_en=0, bubble_r2=1, flush_r1=1.
REQ-033 Reset asserted mid-FLUSH or mid-STALL SHALL abandon the sequence; first cycle after release SHALL be RUN with RUN outputs.

Verification
REQ-034 Reset then idle 3 cycles -> state=00, all enables 1, stall_cnt=0, flush_cnt=0.
REQ-035 update_pc pulse with FLUSH_LEN=2 -> cycle0 flush_r1=1, bubble_r2=1; cycles1-2 state=10, bubble_r2=1; cycle3 state=00; flush_cnt=1.
REQ-036 freeze high 1 cycle, then mem_busy high 4 cycles -> pc_en=0 for 5 cycles, state=01 for 4 cycles, stall_cnt=5.
REQ-037 update_pc and mem_busy same cycle in RUN -> STALL entered, flush_cnt=0; update_pc held high after release -> FLUSH entered, flush_cnt=1.
REQ-038 halt_req then resume after 6 cycles -> halted=1 for 6 cycles, pc_en=0 throughout, stall_cnt counts 1 (entry cycle only).
REQ-039 freeze held 300 cycles -> stall_cnt saturates at 255; rst_n low mid-FLUSH -> outputs per REQ-032, RUN after release.
